// File: rtl/id_stage_if.sv
// Fetch/execute handshake bundle around the decode stage.
// The stage uses the slave modport; the driving environment uses master.
interface id_stage_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            flush;
    logic            ex_ready;
    logic            ex_valid;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_pc;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic            ex_funct7_5;
    logic            ex_is_load;
    logic            ex_reg_write;
    logic            ex_illegal;
    logic [15:0]     stall_count;

    modport slave (
        input  if_valid, if_instr, if_pc, flush, ex_ready,
        output if_ready, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_pc,
               ex_opcode, ex_funct3, ex_funct7_5, ex_is_load, ex_reg_write,
               ex_illegal, stall_count
    );

    modport master (
        output if_valid, if_instr, if_pc, flush, ex_ready,
        input  if_ready, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_pc,
               ex_opcode, ex_funct3, ex_funct7_5, ex_is_load, ex_reg_write,
               ex_illegal, stall_count
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: one-entry output register with valid/ready handshake,
// load-use bubble insertion and a saturating bubble counter.
module id_stage #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    id_stage_if.slave  bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7_5;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        is_load;
        logic        reg_write;
        logic        illegal;
    } dec_t;

    // Unused register fields are forced to 0 so hazard compares need no format check.
    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        logic use_rs1;
        logic use_rs2;
        logic use_rd;
        d        = '0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        d.opcode   = instr[6:0];
        d.funct3   = instr[14:12];
        d.funct7_5 = instr[30];
        case (instr[6:0])
            OP_R: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                d.imm   = 32'd0;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                d.imm   = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                d.imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                d.imm   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                use_rd  = 1'b1;
                d.imm   = {instr[31:12], 12'd0};
            end
            OP_JAL: begin
                use_rd  = 1'b1;
                d.imm   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: begin
                d.illegal = 1'b1;
                d.imm     = 32'd0;
            end
        endcase
        d.rs1       = use_rs1 ? instr[19:15] : 5'd0;
        d.rs2       = use_rs2 ? instr[24:20] : 5'd0;
        d.rd        = use_rd  ? instr[11:7]  : 5'd0;
        d.is_load   = (instr[6:0] == OP_LOAD);
        d.reg_write = (d.rd != 5'd0);
        return d;
    endfunction

    state_t          state_q, state_d;
    dec_t            dec_q, dec_d, in_dec_s;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [15:0]     stall_q, stall_d;
    logic            hazard_s;
    logic            if_ready_s;
    logic            xfer_s;

    // Decode the incoming word and derive handshake / hazard conditions.
    always_comb begin
        in_dec_s   = decode(bus.if_instr);
        hazard_s   = (state_q == FULL) && dec_q.is_load && (dec_q.rd != 5'd0) && bus.if_valid &&
                     ((in_dec_s.rs1 == dec_q.rd) || (in_dec_s.rs2 == dec_q.rd));
        if_ready_s = ((state_q == EMPTY) || bus.ex_ready) && !hazard_s && !bus.flush;
        xfer_s     = bus.if_valid && if_ready_s;
    end

    // Next-state: flush wins, then transfer, then drain when execute consumes.
    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        pc_d    = pc_q;
        stall_d = stall_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else if (xfer_s) begin
            state_d = FULL;
            dec_d   = in_dec_s;
            pc_d    = bus.if_pc;
        end else if (bus.ex_ready) begin
            state_d = EMPTY;
        end else begin
            state_d = state_q;
        end
        // A bubble is only inserted when the held load actually leaves.
        if (hazard_s && bus.ex_ready && !bus.flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stage register and bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            dec_q   <= '0;
            pc_q    <= '0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            pc_q    <= pc_d;
            stall_q <= stall_d;
        end
    end

    assign bus.if_ready     = if_ready_s;
    assign bus.ex_valid     = (state_q == FULL);
    assign bus.ex_rs1       = dec_q.rs1;
    assign bus.ex_rs2       = dec_q.rs2;
    assign bus.ex_rd        = dec_q.rd;
    assign bus.ex_imm       = XLEN'($signed(dec_q.imm));
    assign bus.ex_pc        = pc_q;
    assign bus.ex_opcode    = dec_q.opcode;
    assign bus.ex_funct3    = dec_q.funct3;
    assign bus.ex_funct7_5  = dec_q.funct7_5;
    assign bus.ex_is_load   = dec_q.is_load;
    assign bus.ex_reg_write = dec_q.reg_write;
    assign bus.ex_illegal   = dec_q.illegal;
    assign bus.stall_count  = stall_q;
endmodule
